// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Registered execute-stage ALU with valid/ready handshake,
//                iterative shift-add multiplier, zero flag and branch-taken
//                strobe. Optional unsigned restoring divider enabled by the
//                macro ALU_PIPE_DIVU_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       alu_op,
  input  logic [3:0]       ex_cmd,
  input  logic             branch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             branch_taken,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
`ifdef ALU_PIPE_DIVU_EN
    ,
    DIV  = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;    // multiplicand / divisor
  logic [WIDTH-1:0] mplier_q, mplier_d;  // multiplier / dividend-quotient
  logic [WIDTH-1:0] acc_q, acc_d;        // product accumulator / remainder
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d;
  logic             br_q, br_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] sc_res;
  logic             is_mul;
  logic             is_div;
  logic             accept;

  assign in_ready     = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept       = in_valid && in_ready;
  assign out_valid    = out_valid_q;
  assign alu_out      = alu_out_q;
  assign zero         = zero_q;
  assign branch_taken = out_valid_q && zero_q && br_q;
  assign busy         = (state_q != IDLE);

  assign is_mul = (alu_op == 2'b10) && (ex_cmd == 4'b1111);
`ifdef ALU_PIPE_DIVU_EN
  assign is_div = (alu_op == 2'b10) && (ex_cmd == 4'b1100);

  // One restoring-division step: shift next dividend bit into the remainder.
  logic [WIDTH:0] rem_t;
  logic [WIDTH:0] rem_sub;
  logic           rem_ge;
  assign rem_t   = {acc_q, mplier_q[WIDTH-1]};
  assign rem_sub = rem_t - {1'b0, mcand_q};
  assign rem_ge  = (rem_t >= {1'b0, mcand_q});
`else
  assign is_div = 1'b0;
`endif

  // Single-cycle result decode; unknown codes and alu_op=11 yield zero.
  always_comb begin
    sc_res = '0;
    case (alu_op)
      2'b00: sc_res = in_a + in_b;
      2'b01: sc_res = in_a - in_b;
      2'b10: begin
        case (ex_cmd)
          4'b0010: sc_res = in_a + in_b;
          4'b0110: sc_res = in_a - in_b;
          4'b0000: sc_res = in_a & in_b;
          4'b0001: sc_res = in_a | in_b;
          4'b0101: sc_res = in_a ^ in_b;
          4'b0111: sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
          4'b1000: sc_res = in_a << in_b[SHW-1:0];
          4'b1001: sc_res = in_a >> in_b[SHW-1:0];
          4'b1010: sc_res = $unsigned($signed(in_a) >>> in_b[SHW-1:0]);
          default: sc_res = '0;
        endcase
      end
      default: sc_res = '0;
    endcase
  end

  // Next-state: handshake, output hold, iterative multiply/divide, flush.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    br_d        = br_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (out_valid_q && out_ready) out_valid_d = 1'b0;
          if (accept) begin
            br_d = branch;
            if (is_mul) begin
              state_d     = MUL;
              cnt_d       = CW'(WIDTH);
              mcand_d     = in_a;
              mplier_d    = in_b;
              acc_d       = '0;
              out_valid_d = 1'b0;
`ifdef ALU_PIPE_DIVU_EN
            end else if (is_div) begin
              state_d     = DIV;
              cnt_d       = CW'(WIDTH);
              mcand_d     = in_b;
              mplier_d    = in_a;
              acc_d       = '0;
              out_valid_d = 1'b0;
`endif
            end else begin
              alu_out_d   = sc_res;
              zero_d      = (sc_res == '0);
              out_valid_d = 1'b1;
            end
          end
        end
        MUL: begin
          if (cnt_q == '0) begin
            alu_out_d   = acc_q;
            zero_d      = (acc_q == '0);
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
          end
        end
`ifdef ALU_PIPE_DIVU_EN
        DIV: begin
          if (cnt_q == '0) begin
            alu_out_d   = mplier_q;
            zero_d      = (mplier_q == '0);
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Divide by zero always subtracts, giving an all-ones quotient.
            acc_d    = rem_ge ? rem_sub[WIDTH-1:0] : rem_t[WIDTH-1:0];
            mplier_d = {mplier_q[WIDTH-2:0], rem_ge};
            cnt_d    = cnt_q - CW'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      br_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      br_q        <= br_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed self-checking bench for alu_pipe (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   alu_op = '0;
  logic [3:0]   ex_cmd = '0;
  logic         branch = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic         zero;
  logic         branch_taken;
  logic         busy;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .alu_op(alu_op), .ex_cmd(ex_cmd), .branch(branch),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .zero(zero), .branch_taken(branch_taken), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Offer one op at the falling edge, let it be accepted at the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] cmd,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic br);
    @(negedge clk);
    alu_op = op; ex_cmd = cmd; in_a = a; in_b = b; branch = br; in_valid = 1'b1;
    #1 chk("in_ready_at_issue", W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_a = '1; in_b = '1;
  endtask

  // Count rising edges after acceptance until out_valid, bounded.
  task automatic wait_result(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      chk("busy_while_iterating", W'(busy), W'(1));
      @(posedge clk);
      #1 n++;
    end
  endtask

  initial begin
    int n;
    logic seen;
    // Reset state
    #12;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_alu_out", alu_out, '0);
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_branch_taken", W'(branch_taken), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    @(negedge clk) rst_n = 1'b1;
    #1 chk("in_ready_after_rst", W'(in_ready), W'(1));
    out_ready = 1'b1;

    issue(2'b00, 4'h0, 32'd3, 32'd4, 1'b0);
    chk("add_valid", W'(out_valid), W'(1));
    chk("add_3_4", alu_out, 32'd7);
    chk("add_zero", W'(zero), W'(0));

    // Back-to-back single-cycle ops
    issue(2'b00, 4'h0, 32'd5, 32'd6, 1'b0);       chk("b2b_add", alu_out, 32'd11);
    issue(2'b01, 4'h0, 32'd10, 32'd3, 1'b0);      chk("b2b_sub", alu_out, 32'd7);
    issue(2'b10, 4'b0000, 32'hF0, 32'h3C, 1'b0);  chk("b2b_and", alu_out, 32'h30);
    issue(2'b10, 4'b1010, 32'h8000_0000, 32'd4, 1'b0); chk("b2b_sra", alu_out, 32'hF800_0000);
    chk("b2b_valid", W'(out_valid), W'(1));
    issue(2'b10, 4'b0101, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0); chk("xor", alu_out, 32'hF00F_F00F);
    issue(2'b10, 4'b0001, 32'hF0, 32'h0F, 1'b0);  chk("or", alu_out, 32'hFF);
    issue(2'b10, 4'b1000, 32'd1, 32'h3F, 1'b0);   chk("sll_masked", alu_out, 32'h8000_0000);
    issue(2'b10, 4'b1001, 32'h8000_0000, 32'd31, 1'b0); chk("srl", alu_out, 32'd1);
    issue(2'b10, 4'b0111, 32'd5, 32'hFFFF_FFFD, 1'b0);  chk("slt_false", alu_out, 32'd0);
    issue(2'b10, 4'b0011, 32'd5, 32'd6, 1'b0);    chk("undef_cmd", alu_out, 32'd0);
    chk("undef_zero", W'(zero), W'(1));
    issue(2'b11, 4'h0, 32'd9, 32'd1, 1'b1);
    chk("op11_out", alu_out, 32'd0);
    chk("op11_branch_taken", W'(branch_taken), W'(1));

    // Branch compare
    issue(2'b01, 4'h0, 32'd42, 32'd42, 1'b1);
    chk("br_eq_zero", W'(zero), W'(1));
    chk("br_eq_taken", W'(branch_taken), W'(1));
    @(posedge clk); #1;
    chk("br_consumed_valid", W'(out_valid), W'(0));
    chk("br_consumed_taken", W'(branch_taken), W'(0));
    issue(2'b01, 4'h0, 32'd42, 32'd41, 1'b1);
    chk("br_ne_out", alu_out, 32'd1);
    chk("br_ne_taken", W'(branch_taken), W'(0));

    // Multiply with backpressure
    issue(2'b10, 4'b1111, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    out_ready = 1'b0;
    chk("mul_in_ready_low", W'(in_ready), W'(0));
    wait_result(n);
    chk("mul_latency", W'(n), W'(33));
    chk("mul_result", alu_out, 32'hFFFF_FFFF);
    chk("mul_busy_done", W'(busy), W'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_op = 2'b00; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1;
      #1 chk("hold_in_ready", W'(in_ready), W'(0));
      @(posedge clk); #1;
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_value", alu_out, 32'hFFFF_FFFF);
    end
    in_valid = 1'b0;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", W'(out_valid), W'(0));
    chk("hold_no_new_op", alu_out, 32'hFFFF_FFFF);

    issue(2'b10, 4'b1111, 32'd7, 32'd6, 1'b0);
    wait_result(n);
    chk("mul_small_latency", W'(n), W'(33));
    chk("mul_7_6", alu_out, 32'd42);

    // Asynchronous reset mid-multiply
    issue(2'b10, 4'b1111, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_alu_out", alu_out, '0);
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_zero", W'(zero), W'(0));
    chk("arst_branch_taken", W'(branch_taken), W'(0));
    @(negedge clk) rst_n = 1'b1;
    #1 chk("arst_in_ready", W'(in_ready), W'(1));
    issue(2'b00, 4'h0, 32'd3, 32'd4, 1'b0);
    chk("arst_add", alu_out, 32'd7);

    // Flush during multiply
    issue(2'b10, 4'b1111, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; alu_op = 2'b00; in_a = 32'd2; in_b = 32'd2; in_valid = 1'b1;
    #1 chk("flush_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_out_valid", W'(out_valid), W'(0));
    @(negedge clk) begin flush = 1'b0; in_valid = 1'b0; end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_never_valid", W'(seen), W'(0));
    issue(2'b10, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("slt_neg", alu_out, 32'd1);

    // Optional divider
`ifdef ALU_PIPE_DIVU_EN
    issue(2'b10, 4'b1100, 32'd100, 32'd7, 1'b0);
    wait_result(n);
    chk("div_latency", W'(n), W'(33));
    chk("div_100_7", alu_out, 32'd14);
    issue(2'b10, 4'b1100, 32'd5, 32'd0, 1'b0);
    wait_result(n);
    chk("div0_latency", W'(n), W'(33));
    chk("div_by_zero", alu_out, 32'hFFFF_FFFF);
`else
    issue(2'b10, 4'b1100, 32'd100, 32'd7, 1'b0);
    chk("nodiv_valid", W'(out_valid), W'(1));
    chk("nodiv_out", alu_out, 32'd0);
    chk("nodiv_busy", W'(busy), W'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
